simon_datapath: RTL and testbench
=================================

# simon_datapath

Datapath for the Simon pattern-memory game, driven by the Simon control FSM and returning its status inputs. Stores the player's switch patterns in a register-array memory, steps a playback/repeat pointer through them, and generates `pattern_valid`, `pattern_same` and `SeenAll` plus the LED pattern display. It sits between the board switches/LEDs and the controller, and owns all game storage.

## Interface

- `WIDTH`, 4, pattern width in bits (one bit per switch/LED)
- `DEPTH`, 64, maximum stored sequence length
- `ADDR_W`, 6, pointer width; `2**ADDR_W` must equal `DEPTH`

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pattern`  in  WIDTH  live switch pattern
- `level_sw`  in  1  difficulty select; 0 = easy, 1 = hard
- `level_enable`  in  1  load `level_sw` into level register
- `write_enable`  in  1  write `pattern` to `mem[current]` when `pattern_valid`
- `current_rst`  in  1  clear `current` (sequence end index)
- `current_enable`  in  1  advance `current` (commit a round)
- `counter_rst`  in  1  clear `counter` (playback/repeat pointer)
- `counter_enable`  in  1  advance `counter`
- `display_choice`  in  1  0 = show `pattern`, 1 = show `mem[counter]`
- `pattern_valid`  out  1  `pattern` legal for current level
- `pattern_same`  out  1  `pattern == mem[counter]`
- `SeenAll`  out  1  `counter == current`
- `pattern_leds`  out  WIDTH  LED pattern
- `full`  out  1  `current == DEPTH-1`

## Operation

- State: `mem[0..DEPTH-1]` (WIDTH each), `current` and `counter` (ADDR_W each), `level` (1 bit).
- Active sequence is `mem[0..current]` inclusive; `mem[current]` is the slot written by the next input.
- Write: `write_enable && pattern_valid` -> `mem[current] <= pattern`. `write_enable` with invalid pattern: no write.
- `current`: `current_rst` clears (priority); else `current_enable` increments, saturating at `DEPTH-1`; write uses pre-update `current`.
- `counter`: `counter_rst` clears (priority); else `counter_enable` increments, wrapping `DEPTH-1` -> 0.
- `level`: loaded from `level_sw` when `level_enable`; otherwise held.
- `pattern_valid`: easy: `pattern != 0`; hard: exactly one bit set (one-hot).
- `pattern_same`, `SeenAll`, `full`, `pattern_leds`: combinational from `pattern` and registers; memory read is asynchronous at `counter`.
- Intended round: INPUT writes `mem[current]`; PLAYBACK steps `counter` 0..`current`; REPEAT compares each; on `SeenAll && pattern_same` controller pulses `current_enable` so next INPUT writes next slot.

## Timing

- Reset (`rst`=0, async): `mem`, `current`, `counter`, `level` = 0. Hence `SeenAll`=1, `full`=0, `pattern_same` = (`pattern`==0), `pattern_valid` = (`pattern`!=0), `pattern_leds` = `display_choice ? 0 : pattern`.
- Registered updates visible 1 cycle after the enabling edge; status outputs follow in the same cycle, zero added latency.
- Write then read of same address: new data visible on `pattern_leds`/`pattern_same` the cycle after the write edge.
- `current_enable` at `full`: `current` holds `DEPTH-1`; further writes overwrite `mem[DEPTH-1]`.
- Simultaneous `counter_rst` and `counter_enable`: result 0. Same for `current_rst`/`current_enable`.
- Simultaneous write and `current_rst`: write lands at old `current`, then `current`=0.
- `rst` asserted mid-round: all state cleared immediately, independent of `clk`.

## Configuration

- `SIMON_DP_HISCORE_EN` defined: adds output `hiscore` (ADDR_W+1 bits), reset 0, cleared only by `rst`; on each edge where `current` increments, `hiscore <= max(hiscore, current+1)`. Unaffected by `current_rst`/`counter_rst`.
- Not defined: no `hiscore` port or register; all other behaviour identical.

## Test plan

- Reset with `pattern`=4'b0000, `display_choice`=0 -> `SeenAll`=1, `pattern_valid`=0, `pattern_same`=1, `pattern_leds`=0, `full`=0.
- `level_sw`=1 + `level_enable` pulse; `pattern`=4'b0110 -> `pattern_valid`=0, no write; `pattern`=4'b0100 + `write_enable` -> `mem[0]`=4'b0100, `display_choice`=1 shows 4'b0100.
- Store 3 rounds (write 1,2,4; `current_enable` after each of first two) then playback with `counter_enable` -> `pattern_leds` 1,2,4; `SeenAll` high only at `counter`=2.
- Repeat phase, `counter`=1, `pattern`=4'b1000 vs stored 4'b0010 -> `pattern_same`=0; `counter_rst` -> `counter`=0.
- 64 `current_enable` pulses -> `full`=1 after 63, `current` stays 63; `counter_enable` at 63 -> `counter`=0.
- With `SIMON_DP_HISCORE_EN`: reach `current`=5, `current_rst`, reach `current`=2 -> `hiscore`=5; `rst` -> `hiscore`=0.

Source files
------------

// File: rtl/simon_datapath.sv
// rtl/simon_datapath.sv - Simon game datapath: pattern memory, round/playback pointers, status and LED outputs
// Optional feature: define SIMON_DP_HISCORE_EN to add the hiscore output (best sequence length reached).
module simon_datapath #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pattern,
  input  logic              level_sw,
  input  logic              level_enable,
  input  logic              write_enable,
  input  logic              current_rst,
  input  logic              current_enable,
  input  logic              counter_rst,
  input  logic              counter_enable,
  input  logic              display_choice,
  output logic              pattern_valid,
  output logic              pattern_same,
  output logic              SeenAll,
  output logic [WIDTH-1:0]  pattern_leds,
`ifdef SIMON_DP_HISCORE_EN
  output logic              full,
  output logic [ADDR_W:0]   hiscore
`else
  output logic              full
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] current;
  logic [ADDR_W-1:0] counter;
  logic              level;
  logic [WIDTH-1:0]  rd_data;
  logic              nonzero;
  logic              one_hot;
  logic              current_inc;

  // Asynchronous read at the playback/repeat pointer
  assign rd_data = mem[counter];

  // Easy level accepts any non-empty pattern, hard level only a single switch
  assign nonzero       = (pattern != '0);
  assign one_hot       = nonzero && ((pattern & (pattern - WIDTH'(1))) == '0);
  assign pattern_valid = level ? one_hot : nonzero;

  assign pattern_same  = (pattern == rd_data);
  assign SeenAll       = (counter == current);
  assign full          = (current == LAST);
  assign pattern_leds  = display_choice ? rd_data : pattern;

  // current only moves when it is not already at the last slot
  assign current_inc   = !current_rst && current_enable && !full;

  // Pattern store; writes use the pointer value before any update this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_enable && pattern_valid) begin
      mem[current] <= pattern;
    end
  end

  // Sequence end index: clear has priority, increment saturates at the last slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current <= '0;
    end else if (current_rst) begin
      current <= '0;
    end else if (current_inc) begin
      current <= current + 1'b1;
    end
  end

  // Playback/repeat pointer: clear has priority, increment wraps naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
    end else if (counter_rst) begin
      counter <= '0;
    end else if (counter_enable) begin
      counter <= counter + 1'b1;
    end
  end

  // Difficulty register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
    end else if (level_enable) begin
      level <= level_sw;
    end
  end

`ifdef SIMON_DP_HISCORE_EN
  logic [ADDR_W:0] current_len;

  // Length of the sequence once current steps forward
  assign current_len = {1'b0, current} + (ADDR_W + 1)'(1);

  // Best length ever reached; survives round and pointer clears, only rst clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hiscore <= '0;
    end else if (current_inc && (current_len > hiscore)) begin
      hiscore <= current_len;
    end
  end
`endif

endmodule

// File: tb/tb_simon_datapath.sv
// tb/tb_simon_datapath.sv - scoreboard bench for simon_datapath
module tb_simon_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pattern = '0;
  logic       level_sw = 1'b0, level_enable = 1'b0, write_enable = 1'b0;
  logic       current_rst = 1'b0, current_enable = 1'b0;
  logic       counter_rst = 1'b0, counter_enable = 1'b0, display_choice = 1'b0;
  logic       pattern_valid, pattern_same, SeenAll, full;
  logic [3:0] pattern_leds;
`ifdef SIMON_DP_HISCORE_EN
  logic [6:0] hiscore;
`endif

  int checks = 0;
  int passes = 0;

  string      q_name [$];
  logic [7:0] q_exp  [$];
  logic [7:0] q_hs   [$];

  simon_datapath #(.WIDTH(4), .DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .pattern(pattern), .level_sw(level_sw),
    .level_enable(level_enable), .write_enable(write_enable),
    .current_rst(current_rst), .current_enable(current_enable),
    .counter_rst(counter_rst), .counter_enable(counter_enable),
    .display_choice(display_choice), .pattern_valid(pattern_valid),
    .pattern_same(pattern_same), .SeenAll(SeenAll), .pattern_leds(pattern_leds),
`ifdef SIMON_DP_HISCORE_EN
    .full(full), .hiscore(hiscore)
`else
    .full(full)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs for the inputs currently applied, checked on the next falling edge
  task automatic expect_out(input string name, input logic pv, input logic ps,
                            input logic sa, input logic fl, input logic [3:0] leds);
    q_name.push_back(name);
    q_exp.push_back({pv, ps, sa, fl, leds});
    q_hs.push_back(8'h00);
  endtask

  task automatic expect_hs(input string name, input logic [6:0] hs);
    q_name.push_back(name);
    q_exp.push_back(8'h00);
    q_hs.push_back({1'b1, hs});
  endtask

  task automatic ctl_idle();
    level_enable = 0; write_enable = 0; current_rst = 0; current_enable = 0;
    counter_rst = 0; counter_enable = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the scoreboard each falling edge against the live outputs
  initial begin
    string nm;
    logic [7:0] ex, hs, act;
    forever begin
      @(negedge clk);
      while (q_exp.size() > 0) begin
        nm = q_name.pop_front();
        ex = q_exp.pop_front();
        hs = q_hs.pop_front();
        checks++;
        if (hs[7]) begin
`ifdef SIMON_DP_HISCORE_EN
          act = {1'b1, hiscore};
`else
          act = 8'hxx;
`endif
          if (act === hs) passes++;
          else $display("FAIL %s hiscore got %0d want %0d", nm, act[6:0], hs[6:0]);
        end else begin
          act = {pattern_valid, pattern_same, SeenAll, full, pattern_leds};
          if (act === ex) passes++;
          else $display("FAIL %s {valid,same,seenall,full,leds} got %b want %b", nm, act, ex);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    expect_out("reset", 0, 1, 1, 0, 4'b0000);
    tick();
    rst = 1;
    // Select hard level; level still easy during this cycle
    level_sw = 1; level_enable = 1; pattern = 4'b0000;
    expect_out("level_load", 0, 1, 1, 0, 4'b0000);
    tick(); ctl_idle();
    // Two bits set is illegal in hard mode: write suppressed
    pattern = 4'b0110; write_enable = 1;
    expect_out("hard_invalid", 0, 0, 1, 0, 4'b0110);
    tick(); ctl_idle();
    display_choice = 1;
    expect_out("no_write_invalid", 0, 0, 1, 0, 4'b0000);
    tick();
    pattern = 4'b0100; write_enable = 1;
    expect_out("hard_valid", 1, 0, 1, 0, 4'b0000);
    tick(); ctl_idle();
    expect_out("write_visible", 1, 1, 1, 0, 4'b0100);
    tick();
    // Store 1,2,4; write and current_enable together use the old current
    display_choice = 0;
    pattern = 4'b0001; write_enable = 1; current_enable = 1;
    expect_out("store0", 1, 0, 1, 0, 4'b0001);
    tick();
    pattern = 4'b0010;
    expect_out("store1", 1, 0, 0, 0, 4'b0010);
    tick(); current_enable = 0;
    pattern = 4'b0100;
    expect_out("store2", 1, 0, 0, 0, 4'b0100);
    tick(); ctl_idle();
    // Playback
    display_choice = 1; pattern = 4'b0000; counter_enable = 1;
    expect_out("play0", 0, 0, 0, 0, 4'b0001);
    tick();
    expect_out("play1", 0, 0, 0, 0, 4'b0010);
    tick(); counter_enable = 0;
    expect_out("play2", 0, 0, 1, 0, 4'b0100);
    tick();
    // Simultaneous counter clear and advance gives zero
    counter_rst = 1; counter_enable = 1;
    expect_out("cnt_rst_en", 0, 0, 1, 0, 4'b0100);
    tick(); counter_rst = 0;
    display_choice = 0; pattern = 4'b0001;
    expect_out("repeat_match0", 1, 1, 0, 0, 4'b0001);
    tick(); counter_enable = 0;
    pattern = 4'b1000;
    expect_out("repeat_mismatch", 1, 0, 0, 0, 4'b1000);
    tick();
    pattern = 4'b0010; counter_rst = 1;
    expect_out("repeat_match1", 1, 1, 0, 0, 4'b0010);
    tick(); counter_rst = 0;
    expect_out("counter_cleared", 1, 0, 0, 0, 4'b0010);
    tick();
    // Write together with current_rst lands at old current (2)
    pattern = 4'b1000; write_enable = 1; current_rst = 1; current_enable = 1;
    expect_out("write_cur_rst", 1, 0, 0, 0, 4'b1000);
    tick(); ctl_idle();
    display_choice = 1; pattern = 4'b0000; counter_enable = 1;
    expect_out("cur_rst_applied", 0, 0, 1, 0, 4'b0001);
    tick();
    expect_out("walk1", 0, 0, 0, 0, 4'b0010);
    tick(); counter_enable = 0;
    expect_out("write_at_old_cur", 0, 0, 0, 0, 4'b1000);
    tick();
    // 64 current_enable pulses with counter parked at 2
    display_choice = 0; current_enable = 1;
    for (int i = 0; i < 64; i++) begin
      expect_out($sformatf("fill%0d", i), 0, 0, i == 2, i == 63, 4'b0000);
      tick();
    end
    current_enable = 0;
    expect_out("full_hold", 0, 0, 0, 1, 4'b0000);
`ifdef SIMON_DP_HISCORE_EN
    expect_hs("hiscore_full", 7'd63);
`endif
    tick();
    // Walk counter to 63, then wrap
    counter_rst = 1;
    tick(); counter_rst = 0; counter_enable = 1;
    for (int i = 0; i < 63; i++) begin
      expect_out($sformatf("walk_cnt%0d", i), 0, i >= 3, 0, 1, 4'b0000);
      tick();
    end
    expect_out("cnt63", 0, 1, 1, 1, 4'b0000);
    tick(); counter_enable = 0;
    expect_out("counter_wrap", 0, 0, 0, 1, 4'b0000);
    tick();
    // Asynchronous reset mid-round, checked before any further clock edge
    rst = 0;
    expect_out("async_rst", 0, 1, 1, 0, 4'b0000);
`ifdef SIMON_DP_HISCORE_EN
    expect_hs("hiscore_rst0", 7'd0);
`endif
    tick();
    rst = 1;
`ifdef SIMON_DP_HISCORE_EN
    current_enable = 1;
    repeat (5) tick();
    current_enable = 0; current_rst = 1; counter_rst = 1;
    tick(); current_rst = 0; counter_rst = 0; current_enable = 1;
    repeat (2) tick();
    current_enable = 0;
    expect_hs("hiscore_keep", 7'd5);
    tick();
    rst = 0;
    expect_hs("hiscore_rst", 7'd0);
    tick();
    rst = 1;
`endif
    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      $display("FAIL drain pending got %0d want 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
